mips_mem_responder: RTL

//  Memory-side responder for the MIPS CPU data/instruction memory port. The CPU is the initiator.

---
 rtl/mips_mem_responder.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/mips_mem_responder.sv
// rtl/mips_mem_responder.sv - MIPS CPU memory-port responder with programmable request/response latency
// Word RAM behind a request valid/ready handshake and a separate read-data valid/ready channel.
module mips_mem_responder #(
    parameter int MEM_DEPTH_LOG2 = 10,
    parameter int REQ_LATENCY    = 2,
    parameter int RESP_LATENCY   = 1
) (
    input  logic        mips_cpu_clk,
    input  logic        mips_cpu_reset,
    input  logic [31:0] Address,
    input  logic        MemWrite,
    input  logic [31:0] Write_data,
    input  logic [3:0]  Write_strb,
    input  logic        MemRead,
    output logic        Mem_Req_Ready,
    output logic [31:0] Read_data,
    output logic        Read_data_Valid,
    input  logic        Read_data_Ready
);

    localparam int DEPTH = 1 << MEM_DEPTH_LOG2;
    // Counts are preloaded one (request) or two (response) short so the registered
    // outputs land on cycle L+1 for ready and ACCEPT+max(R,1) for valid.
    localparam logic [3:0] C_REQ_CNT  = (REQ_LATENCY > 0)  ? 4'(REQ_LATENCY - 1)  : 4'd0;
    localparam logic [3:0] C_RESP_CNT = (RESP_LATENCY > 1) ? 4'(RESP_LATENCY - 2) : 4'd0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_REQ,
        S_ACCEPT,
        S_WAIT_RESP,
        S_RESP
    } state_t;

    state_t                    r_state, w_state_nx;
    logic [3:0]                r_cnt, w_cnt_nx;
    logic                      r_ready, w_ready_nx;
    logic                      r_valid, w_valid_nx;
    logic [31:0]               r_rdata;
    logic [MEM_DEPTH_LOG2-1:0] r_index;
    logic [MEM_DEPTH_LOG2-1:0] w_index;
    logic [MEM_DEPTH_LOG2-1:0] w_rd_index;
    logic                      w_req;
    logic                      w_wr_en;
    logic                      w_rd_acc;
    logic                      w_load;
    logic                      w_unused_addr;
    logic [31:0]               r_mem [0:DEPTH-1];

    assign w_req         = MemRead | MemWrite;
    assign w_index       = Address[MEM_DEPTH_LOG2+1:2];
    assign w_unused_addr = ^{Address[31:MEM_DEPTH_LOG2+2], Address[1:0]};
    assign w_rd_index    = (r_state == S_ACCEPT) ? w_index : r_index;

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_ready_nx = 1'b0;
        w_valid_nx = r_valid;
        w_wr_en    = 1'b0;
        w_rd_acc   = 1'b0;
        w_load     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    if (REQ_LATENCY == 0) begin
                        w_state_nx = S_ACCEPT;
                        w_ready_nx = 1'b1;
                    end else begin
                        w_state_nx = S_WAIT_REQ;
                        w_cnt_nx   = C_REQ_CNT;
                    end
                end
            end
            S_WAIT_REQ: begin
                if (r_cnt != 4'd0) begin
                    w_cnt_nx = r_cnt - 4'd1;
                end else if (w_req) begin
                    w_state_nx = S_ACCEPT;
                    w_ready_nx = 1'b1;
                end else begin
                    w_state_nx = S_IDLE;
                end
            end
            S_ACCEPT: begin
                if (!w_req) begin
                    w_state_nx = S_IDLE;
                end else if (MemWrite) begin
                    w_wr_en    = 1'b1;
                    w_state_nx = S_IDLE;
                end else begin
                    w_rd_acc = 1'b1;
                    if (RESP_LATENCY <= 1) begin
                        w_load     = 1'b1;
                        w_valid_nx = 1'b1;
                        w_state_nx = S_RESP;
                    end else begin
                        w_cnt_nx   = C_RESP_CNT;
                        w_state_nx = S_WAIT_RESP;
                    end
                end
            end
            S_WAIT_RESP: begin
                if (r_cnt != 4'd0) begin
                    w_cnt_nx = r_cnt - 4'd1;
                end else begin
                    w_load     = 1'b1;
                    w_valid_nx = 1'b1;
                    w_state_nx = S_RESP;
                end
            end
            S_RESP: begin
                if (Read_data_Ready) begin
                    w_valid_nx = 1'b0;
                    w_state_nx = S_IDLE;
                end
            end
            default: begin
                w_state_nx = S_IDLE;
                w_valid_nx = 1'b0;
            end
        endcase
    end

    always_ff @(posedge mips_cpu_clk or negedge mips_cpu_reset) begin
        if (!mips_cpu_reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_ready <= 1'b0;
            r_valid <= 1'b0;
            r_rdata <= 32'd0;
            r_index <= '0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_ready <= w_ready_nx;
            r_valid <= w_valid_nx;
            if (w_load) begin
                r_rdata <= r_mem[w_rd_index];
            end
            if (w_rd_acc) begin
                r_index <= w_index;
            end
        end
    end

    // RAM is deliberately not reset; reset forces IDLE so no write can fire under it.
    always_ff @(posedge mips_cpu_clk) begin
        if (w_wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (Write_strb[i]) begin
                    r_mem[w_index][8*i +: 8] <= Write_data[8*i +: 8];
                end
            end
        end
    end

    assign Mem_Req_Ready   = r_ready;
    assign Read_data_Valid = r_valid;
    assign Read_data       = r_rdata;

endmodule
